// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x (OVERSAMPLE) tick-based bit recovery and optional even parity.
// Emits one registered valid pulse per frame with parity and framing status.
module uart_rx_oversampled #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic                 parity_en,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_data_error,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] SAMPLE_PT = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction

  state_t                 state, state_next;
  logic                   rx_meta, rxs;
  logic [TW-1:0]          tcnt;
  logic [BW-1:0]          bcnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   par_en_l;
  logic                   parity_bit;

  logic at_sample, at_bound;
  logic start_det, shift_en, bcnt_clr, bcnt_inc, par_cap, frame_done;

  assign at_sample = clk_enable && (tcnt == SAMPLE_PT);
  assign at_bound  = clk_enable && (tcnt == LAST_TICK);

  // Two-flop synchronizer; resets to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_uart;
      rxs     <= rx_meta;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    shift_en   = 1'b0;
    bcnt_clr   = 1'b0;
    bcnt_inc   = 1'b0;
    par_cap    = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (clk_enable && !rxs) begin
          state_next = START;
          start_det  = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      START: begin
        if (at_sample && rxs) begin
          state_next = IDLE;
        end else if (at_bound) begin
          state_next = DATA;
          bcnt_clr   = 1'b1;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        shift_en = at_sample;
        if (at_bound) begin
          if (bcnt == LAST_BIT) begin
            state_next = par_en_l ? PARITY : STOP;
          end else begin
            bcnt_inc = 1'b1;
          end
        end else begin
          state_next = DATA;
        end
      end
      PARITY: begin
        par_cap = at_sample;
        if (at_bound) begin
          state_next = STOP;
        end else begin
          state_next = PARITY;
        end
      end
      STOP: begin
        // The second half of the stop bit is not waited out so back-to-back starts are caught.
        if (at_sample) begin
          frame_done = 1'b1;
          state_next = rxs ? IDLE : WAIT_IDLE;
        end else begin
          state_next = STOP;
        end
      end
      WAIT_IDLE: begin
        if (clk_enable && rxs) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tick/bit counters, shift register and per-frame latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt       <= '0;
      bcnt       <= '0;
      shift      <= '0;
      par_en_l   <= 1'b0;
      parity_bit <= 1'b0;
    end else begin
      if (start_det) begin
        tcnt     <= '0;
        par_en_l <= parity_en;
      end else if (clk_enable) begin
        tcnt <= (tcnt == LAST_TICK) ? '0 : tcnt + TW'(1);
      end
      if (bcnt_clr) begin
        bcnt <= '0;
      end else if (bcnt_inc) begin
        bcnt <= bcnt + BW'(1);
      end
      if (shift_en) begin
        shift <= {rxs, shift[DATA_BITS-1:1]};
      end
      if (par_cap) begin
        parity_bit <= rxs;
      end
    end
  end

  // Registered frame results and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_data_error <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rx_data_valid <= frame_done;
      busy          <= (state_next != IDLE);
      if (frame_done) begin
        rx_data       <= shift;
        rx_parity_err <= par_en_l & even_parity_err(shift, parity_bit);
        rx_frame_err  <= ~rxs;
        rx_data_error <= (par_en_l & even_parity_err(shift, parity_bit)) | ~rxs;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: table-driven frames plus corner sequences,
// with a scoreboard queue compared against every rx_data_valid pulse.
module tb_uart_rx_oversampled;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk_enable = 1'b0;
  logic       parity_en = 1'b0;
  logic       rx_uart = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_parity_err, rx_frame_err, rx_data_error, busy;

  int checks = 0;
  int errors = 0;
  int ce_div = 1;
  int ce_cnt = 0;
  int n_valid = 0;
  int n_pushed = 0;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       pbit;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .parity_en(parity_en),
    .rx_uart(rx_uart), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_data_error(rx_data_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // Oversampling tick: one clk in every ce_div.
  always @(negedge clk) begin
    if (ce_cnt >= ce_div - 1) begin
      ce_cnt = 0;
      clk_enable = 1'b1;
    end else begin
      ce_cnt = ce_cnt + 1;
      clk_enable = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    sb.push_back('{data: d, perr: pe, ferr: fe});
    n_pushed++;
  endtask

  task automatic send_bit(input logic b);
    rx_uart = b;
    repeat (16 * ce_div) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit, input logic stop);
    parity_en = pe;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pe) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx_uart = 1'b1;
    repeat (n * 16 * ce_div) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic prev_valid;
    logic busy_seen;
    logic [7:0] abort_byte;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hE1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    fork
      begin
        prev_valid = 1'b0;
        forever begin
          @(negedge clk);
          if (prev_valid) check("valid_pulse_width", {31'd0, rx_data_valid}, 32'd0);
          if (rx_data_valid) begin
            n_valid++;
            check("unexpected_valid", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
              check("rx_parity_err", {31'd0, rx_parity_err}, {31'd0, e.perr});
              check("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, e.ferr});
              check("rx_data_error", {31'd0, rx_data_error}, {31'd0, e.perr | e.ferr});
            end
          end
          prev_valid = rx_data_valid;
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, rx_data_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_perr", {31'd0, rx_parity_err}, 32'd0);
    check("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
    check("rst_derr", {31'd0, rx_data_error}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle_bits(1);

    // Table-driven frames at one tick per clk
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].data, vecs[v].exp_perr, vecs[v].exp_ferr);
      send_frame(vecs[v].data, vecs[v].par_en, vecs[v].pbit, vecs[v].stop);
      idle_bits(2);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
    end

    // Glitch: 4 ticks low is a false start
    parity_en = 1'b0;
    busy_seen = 1'b0;
    rx_uart = 1'b0;
    repeat (4) @(negedge clk);
    rx_uart = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    check("glitch_busy_pulse", {31'd0, busy_seen}, 32'd1);
    check("glitch_busy_idle", {31'd0, busy}, 32'd0);
    check("glitch_no_valid", n_valid, n_pushed);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    idle_bits(2);

    // Break: 20 bit times low gives one frame error only
    push(8'h00, 1'b0, 1'b1);
    rx_uart = 1'b0;
    repeat (20 * 16 * ce_div) @(negedge clk);
    check("break_busy_wait", {31'd0, busy}, 32'd1);
    idle_bits(2);
    check("break_busy_idle", {31'd0, busy}, 32'd0);
    check("break_one_valid", n_valid, n_pushed);
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1);
    idle_bits(2);

    // Reset during data bit 3 aborts the frame silently
    abort_byte = 8'hFA;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(abort_byte[i]);
    rx_uart = abort_byte[3];
    repeat (8) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    idle_bits(6);
    check("abort_no_valid", n_valid, n_pushed);
    push(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle_bits(2);

    // Back-to-back frames with a tick every 4th clk
    ce_div = 4;
    idle_bits(1);
    push(8'h01, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    idle_bits(2);

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("valid_count", n_valid, n_pushed);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

Standalone UART receiver that recovers asynchronous serial frames from `rx_uart` using a 16x-oversampling tick (`clk_enable`) supplied by the shared baud-rate divider. It is the far-end counterpart of the UART transmit path: it decodes 8-bit, LSB-first frames with optional even parity. Each byte is presented as a one-cycle valid pulse with parity and framing status, ready to push into an AXI-Stream FIFO.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first.
- `OVERSAMPLE`, default 16: `clk_enable` ticks per bit period; must be even, ≥4.
- `clk` input, 1 bit: system clock; all logic on rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `clk_enable` input, 1 bit: one-`clk` pulse at OVERSAMPLE × baud; may be tied high.
- `parity_en` input, 1 bit: 1 = frame carries an even-parity bit after the data; sample only while in IDLE.
- `rx_uart` input, 1 bit: asynchronous serial line, idle high.
- `rx_data` output, DATA_BITS: last received byte, held until the next `rx_data_valid`.
- `rx_data_valid` output, 1 bit: one-`clk` pulse per completed frame.
- `rx_parity_err` output, 1 bit: qualified by `rx_data_valid`; parity mismatch.
- `rx_frame_err` output, 1 bit: qualified by `rx_data_valid`; stop bit sampled low.
- `rx_data_error` output, 1 bit: `rx_parity_err | rx_frame_err`, same qualification.
- `busy` output, 1 bit: high whenever the state is not IDLE.

## Operation
- Two-flop synchronizer on `rx_uart`. Both flops reset to 1, so reset can never produce a false start. All decisions use the synchronized value `rxs`.
- Tick counter `tcnt`, width `$clog2(OVERSAMPLE)`. It advances only on `clk_enable`, wraps at OVERSAMPLE-1, and is set to 0 on start detection.
- Sample point: `tcnt == OVERSAMPLE/2-1` (7 for 16). Bit boundary: `tcnt == OVERSAMPLE-1`.
- Bit counter `bcnt` counts 0..DATA_BITS-1. Shift register fills LSB first (shift right, new bit into MSB).
- States and transitions:
  - IDLE → START on a tick with `rxs==0`; `tcnt` is set to 0.
  - START:
    - At the sample point with `rxs==1`: false start, → IDLE.
    - At the sample point with `rxs==0`: remain in START.
    - At the bit boundary: → DATA, with `bcnt=0`.
  - DATA: sample into the shift register at each sample point. At the bit boundary, if `bcnt==DATA_BITS-1`, go to PARITY when `parity_en` is latched as 1, else to STOP; otherwise increment `bcnt`.
  - PARITY: capture the parity bit at the sample point. → STOP at the bit boundary.
  - STOP: sample the stop bit at the sample point.
    - Register the outputs: `rx_data`=shift register, `rx_parity_err`=latched_parity_en & (^data ^ parity_bit), `rx_frame_err`=~stop_bit. Pulse `rx_data_valid`.
    - Then go to IDLE if the stop bit is 1, else to WAIT_IDLE. The half stop bit is not waited out.
  - WAIT_IDLE → IDLE on the first tick with `rxs==1`. This covers break and stuck-low lines: one frame error is reported and no further frames are produced.
- `parity_en` is latched on the IDLE→START transition; changes mid-frame are ignored.
- With `clk_enable` held low, the FSM and counters freeze. Only the synchronizer keeps running.

## Timing
- Reset values: `rx_data`=0, `rx_data_valid`=0, `rx_parity_err`=0, `rx_frame_err`=0, `rx_data_error`=0, `busy`=0. State is IDLE and counters are 0.
- Reset mid-frame aborts the frame with no valid pulse. The first frame after reset release is received normally.
- Start detection happens on the first tick at least 2 `clk` after the line falls (synchronizer delay).
- The stop sample occurs (1+DATA_BITS+P)·OVERSAMPLE + OVERSAMPLE/2-1 ticks after the start-detect tick, where P = latched parity_en. This is 151 ticks for 8N1 and 167 for 8E1.
- `rx_data_valid` and the status outputs are registered. They assert on the `clk` edge following the tick that samples the stop bit, and valid deasserts after exactly one cycle.
- No backpressure exists; a downstream consumer must accept every pulse.
- Back-to-back frames are supported: a new start bit beginning at the stop-bit boundary is detected because IDLE is re-entered mid-stop.

## Test plan
- 8N1, `clk_enable`=1 (16 clk/bit), `parity_en`=0, frame 0x55 → exactly one `rx_data_valid`, `rx_data`=0x55, all error bits 0, `busy` low afterwards.
- `parity_en`=1, frame 0xA5 with parity 0, then frame 0x07 with parity 0 → first: valid with no errors; second: valid with `rx_data`=0x07, `rx_parity_err`=1, `rx_data_error`=1.
- Glitch: line low for 4 ticks then high → no valid, `busy` pulses then returns to 0, and a following 0x3C frame is received correctly.
- Break: line held low for 20 bit times → exactly one valid with `rx_data`=0x00 and `rx_frame_err`=1. Then the line goes high, a 0x81 frame is sent, and it is received with no errors.
- Reset asserted for 2 clk during data bit 3 of a frame, then a clean 0xC3 frame → no output from the aborted frame, 0xC3 received without errors.
- `clk_enable` every 4th clk, back-to-back frames 0x01 then 0xFF with no idle gap → two valids in order with correct data and no errors.
